bnn_dot_accum: RTL and testbench
================================

Name: bnn_dot_accum

Overview:
- Pipelined, parametrised binary-weight dot-product engine; next generation of the combinational 32-channel AND-multiply/adder-tree neuron.
- Each beat takes N_CH activations plus N_CH 1-bit weights and reduces them through a registered adder tree.
- Accumulates cfg_len beats into one neuron result, so vectors longer than N_CH are supported.
- Valid/ready on both sides; sits between the activation buffer and the activation-function/requant stage.

Parameters:
- N_CH, 32: channels per beat; power of two, >=2 (elaboration error otherwise).
- ACT_W, 16: activation width, unsigned.
- MAX_BEATS, 16: maximum beats per vector; power of two.
- L (derived), clog2(N_CH): number of registered adder-tree stages.
- ACC_W (derived), ACT_W+clog2(N_CH)+clog2(MAX_BEATS), plus 1 when SIGNED_WEIGHT_EN is defined: result width. Default 25.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- act_in  in  N_CH*ACT_W  activations; channel i = act_in[i*ACT_W +: ACT_W]
- wgt_in  in  N_CH  weights; wgt_in[i] pairs with channel i
- cfg_len  in  clog2(MAX_BEATS)+1  beats per vector; sampled on the first beat of each vector
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid&&in_ready
- out_data  out  ACC_W  dot-product result
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- vec_cnt  out  16  count of delivered results, wraps

Behaviour:
- Reset: on rst high at the clock edge:
  - in_ready=0 during the reset cycle; out_valid=0, out_data=0, vec_cnt=0.
  - Beat counter=0; all pipeline valid/tag bits=0; accumulator=0.
  - Any partial vector is discarded. Reset mid-operation has the same effect.
- Global enable: en = !(out_valid && !out_ready); in_ready = en && !rst. When en=0, every pipeline register, tag and counter holds.
- Product term: channel i contributes act_i when wgt_in[i]=1, else 0. All sums are zero-extended to full tree width, so there is no overflow at any level.
- Tree:
  - Level k registers N_CH>>k partial sums; level L holds the beat sum.
  - Each level carries a valid bit and first/last tags.
- Beat tagging at acceptance:
  - first = (beat_cnt==0).
  - len_eff = cfg_len latched on the first beat; 0 is treated as 1; values above MAX_BEATS are clamped to MAX_BEATS.
  - last = (beat_cnt==len_eff-1).
  - beat_cnt increments per accepted beat and returns to 0 after the last beat.
  - cfg_len changes mid-vector are ignored.
- Accumulator stage, when a tree output is valid and en=1:
  - first && !last: acc <= sum.
  - !first && !last: acc <= acc + sum.
  - last: out_data <= (first ? sum : acc + sum), out_valid <= 1, acc <= 0.
- Latency: with no stall, a last beat accepted at edge k gives out_valid high after edge k+L+1 (6 cycles at default).
- Throughput: one beat per cycle. Back-to-back vectors are supported with no bubble.
- Output handshake:
  - out_valid and out_data hold stable until out_valid&&out_ready.
  - On that handshake, vec_cnt increments and out_valid clears, unless a new result loads in the same cycle; then out_valid stays 1 with the new data.
- Simultaneous out_ready and a new last beat reaching the accumulator: both proceed, no loss, no duplication.
- vec_cnt wraps 0xFFFF to 0.

Optional Feature:
- Macro: SIGNED_WEIGHT_EN.
- Defined:
  - Weights are ±1 (bit 1 = +act, bit 0 = -act).
  - Tree and accumulator are two's complement; ACC_W gains a sign bit; out_data is signed.
- Undefined: {0,1} AND-style weights, unsigned result as described above.

Test Plan:
- All act=0xFFFF, wgt=all 1, cfg_len=1, out_ready=1 -> out_data=2097120 (0x1FFFE0), out_valid 6 cycles after accept.
- Same data, cfg_len=16, 16 consecutive beats -> single result 33553920 (0x1FFFE00); out_valid exactly one cycle; vec_cnt=1.
- act_i=i, wgt=0xAAAAAAAA, cfg_len=1 -> 256. Then cfg_len=0 with the same beat -> also 256 (treated as length 1).
- out_ready=0, stream of ten len-1 vectors with act=1, all weights 1 -> in_ready drops once the first result is valid. Release out_ready -> ten results of 32 in order, vec_cnt=10, no beat lost.
- cfg_len=4, two beats accepted, rst for one cycle, then a len-1 vector act=1/all weights 1 -> only output is 32; out_valid=0 and vec_cnt=0 immediately after reset.
- SIGNED_WEIGHT_EN defined: act=1, wgt=0 -> -32. Then act=1, wgt=0xFFFF0000 -> 0.

Source files
------------

// File: rtl/bnn_dot_accum_if.sv
// -----------------------------------------------------------------------------
// bnn_dot_accum_if
// Beat and result handshake bundle for the binary-weight dot-product engine.
//
// Signals:
//   act_in    N_CH*ACT_W  activations, channel i = act_in[i*ACT_W +: ACT_W]
//   wgt_in    N_CH        weights, wgt_in[i] pairs with channel i
//   cfg_len   CNT_W       beats per vector (sampled on the first beat)
//   in_valid / in_ready   beat handshake
//   out_data  ACC_W       dot-product result
//   out_valid / out_ready result handshake
//   vec_cnt   16          delivered-result counter (wraps)
//
// Modports: master = activation-buffer side, slave = the engine.
// Optional macro SIGNED_WEIGHT_EN widens ACC_W by one sign bit.
// -----------------------------------------------------------------------------
interface bnn_dot_accum_if #(
  parameter int N_CH      = 32,
  parameter int ACT_W     = 16,
  parameter int MAX_BEATS = 16
);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
`ifdef SIGNED_WEIGHT_EN
  localparam int ACC_W = ACT_W + $clog2(N_CH) + $clog2(MAX_BEATS) + 1;
`else
  localparam int ACC_W = ACT_W + $clog2(N_CH) + $clog2(MAX_BEATS);
`endif

  logic [N_CH*ACT_W-1:0] act_in;
  logic [N_CH-1:0]       wgt_in;
  logic [CNT_W-1:0]      cfg_len;
  logic                  in_valid;
  logic                  in_ready;
  logic [ACC_W-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [15:0]           vec_cnt;

  modport master (
    output act_in, wgt_in, cfg_len, in_valid, out_ready,
    input  in_ready, out_data, out_valid, vec_cnt
  );

  modport slave (
    input  act_in, wgt_in, cfg_len, in_valid, out_ready,
    output in_ready, out_data, out_valid, vec_cnt
  );
endinterface

// File: rtl/bnn_dot_accum.sv
// -----------------------------------------------------------------------------
// bnn_dot_accum
// Pipelined binary-weight dot-product engine. Each accepted beat carries N_CH
// activations and N_CH 1-bit weights; the weighted products go through a
// registered adder tree (product register + L = clog2(N_CH) sum levels), and an
// accumulator stage adds cfg_len consecutive beat sums into one result.
//
// Ports:
//   clk   clock
//   rst   synchronous active-high reset
//   bus   bnn_dot_accum_if.slave (beat input, result output, vec_cnt)
//
// Configuration macro: SIGNED_WEIGHT_EN
//   undefined : weights in {0,1}, product = wgt ? act : 0, unsigned result
//   defined   : weights are +/-1 (1 = +act, 0 = -act), two's-complement result
//
// Flow control: one global enable, en = !(out_valid && !out_ready). When the
// output register is full and not being drained, every stage holds.
// Latency: last beat accepted at edge k -> out_valid after edge k+L+1.
// -----------------------------------------------------------------------------
module bnn_dot_accum #(
  parameter int N_CH      = 32,
  parameter int ACT_W     = 16,
  parameter int MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  bnn_dot_accum_if.slave  bus
);
  localparam int L     = $clog2(N_CH);
  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
`ifdef SIGNED_WEIGHT_EN
  localparam int TREE_W = ACT_W + L + 1;
  localparam int ACC_W  = ACT_W + L + $clog2(MAX_BEATS) + 1;
`else
  localparam int TREE_W = ACT_W + L;
  localparam int ACC_W  = ACT_W + L + $clog2(MAX_BEATS);
`endif
  // All tree levels live in one flat array: level k starts at 2*N_CH - 2*(N_CH>>k).
  localparam int NODES  = 2 * N_CH - 1;
  localparam int ROOT   = NODES - 1;

  if (N_CH < 2 || (N_CH & (N_CH - 1)) != 0) begin : g_bad_n_ch
    $error("bnn_dot_accum: N_CH must be a power of two >= 2");
  end
  if (MAX_BEATS < 1 || (MAX_BEATS & (MAX_BEATS - 1)) != 0) begin : g_bad_max_beats
    $error("bnn_dot_accum: MAX_BEATS must be a power of two");
  end

  function automatic int lvl_off(input int k);
    return 2 * N_CH - 2 * (N_CH >> k);
  endfunction

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic             en;
  logic             accept;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_data_q;
  logic [15:0]      vec_cnt_q;

  assign en           = !(out_valid_q && !bus.out_ready);
  assign bus.in_ready = en && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.vec_cnt   = vec_cnt_q;

  // ---------------------------------------------------------------------------
  // Beat counter and first/last tagging
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] beat_cnt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] len_cfg;
  logic [CNT_W-1:0] len_cur;
  logic             beat_first;
  logic             beat_last;

  // NOTE: every always_comb output is given a default before any condition,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    len_cfg = bus.cfg_len;
    if (bus.cfg_len == '0)
      len_cfg = CNT_W'(1);
    else if (bus.cfg_len > CNT_W'(MAX_BEATS))
      len_cfg = CNT_W'(MAX_BEATS);
  end

  // On the first beat the length comes straight from cfg_len; afterwards the
  // latched copy is used, so mid-vector cfg_len changes are ignored.
  assign len_cur    = (beat_cnt == '0) ? len_cfg : len_q;
  assign beat_first = (beat_cnt == '0);
  assign beat_last  = (beat_cnt == len_cur - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (accept) begin
      if (beat_first)
        len_q <= len_cfg;
      beat_cnt <= beat_last ? '0 : beat_cnt + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Product terms
  // ---------------------------------------------------------------------------
  logic [TREE_W-1:0] prod [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
`ifdef SIGNED_WEIGHT_EN
      prod[i] = bus.wgt_in[i] ?  TREE_W'(bus.act_in[i*ACT_W +: ACT_W])
                              : (TREE_W'(0) - TREE_W'(bus.act_in[i*ACT_W +: ACT_W]));
`else
      prod[i] = bus.wgt_in[i] ? TREE_W'(bus.act_in[i*ACT_W +: ACT_W]) : TREE_W'(0);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Registered adder tree: level 0 = products, level L = beat sum
  // ---------------------------------------------------------------------------
  logic [TREE_W-1:0] node_q [NODES];
  logic [L:0]        vld_q;
  logic [L:0]        first_q;
  logic [L:0]        last_q;

  // NOTE: the tree data registers have no reset; nothing downstream looks at
  // them unless the matching valid bit (which is reset) is set.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < N_CH; i++)
        node_q[i] <= prod[i];
      // TREE_W already covers the full-scale sum, so the adds never overflow.
      for (int k = 1; k <= L; k++)
        for (int j = 0; j < (N_CH >> k); j++)
          node_q[lvl_off(k) + j] <= node_q[lvl_off(k-1) + 2*j]
                                  + node_q[lvl_off(k-1) + 2*j + 1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else if (en) begin
      vld_q   <= {vld_q[L-1:0],   accept};
      first_q <= {first_q[L-1:0], beat_first};
      last_q  <= {last_q[L-1:0],  beat_last};
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator and output register
  // ---------------------------------------------------------------------------
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] acc_q;

`ifdef SIGNED_WEIGHT_EN
  assign sum_ext = ACC_W'($signed(node_q[ROOT]));
`else
  assign sum_ext = ACC_W'(node_q[ROOT]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      vec_cnt_q   <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) begin
        vec_cnt_q   <= vec_cnt_q + 16'd1;
        out_valid_q <= 1'b0;
      end
      // NOTE: this load is written after the drain above on purpose; the later
      // non-blocking assignment wins, so a result arriving in the same cycle as
      // the handshake keeps out_valid high with the new data.
      if (en && vld_q[L]) begin
        if (last_q[L]) begin
          out_data_q  <= first_q[L] ? sum_ext : acc_q + sum_ext;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
        end else if (first_q[L]) begin
          acc_q <= sum_ext;
        end else begin
          acc_q <= acc_q + sum_ext;
        end
      end
    end
  end
endmodule

// File: tb/tb_bnn_dot_accum.sv
// -----------------------------------------------------------------------------
// tb_bnn_dot_accum
// Directed bench for bnn_dot_accum at default parameters. Inputs are driven on
// the falling edge; DUT outputs are sampled 2 time units after the falling edge.
// Expected values are hand-computed; SIGNED_WEIGHT_EN selects the signed table.
// -----------------------------------------------------------------------------
module tb_bnn_dot_accum;
  localparam int N_CH      = 32;
  localparam int ACT_W     = 16;
  localparam int MAX_BEATS = 16;
  localparam int L         = 5;
  localparam int CL_W      = 5;
  localparam int LAT       = L + 1;
`ifdef SIGNED_WEIGHT_EN
  localparam int ACC_W = 26;
`else
  localparam int ACC_W = 25;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bnn_dot_accum_if #(.N_CH(N_CH), .ACT_W(ACT_W), .MAX_BEATS(MAX_BEATS)) bus ();

  bnn_dot_accum #(.N_CH(N_CH), .ACT_W(ACT_W), .MAX_BEATS(MAX_BEATS)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef logic [N_CH*ACT_W-1:0] act_t;
  typedef logic [N_CH-1:0]       wgt_t;
  typedef logic [CL_W-1:0]       len_t;
  typedef logic [ACC_W-1:0]      res_t;

  typedef struct {
    string  name;
    act_t   act;
    wgt_t   wgt;
    len_t   len;
    longint exp;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  res_t res_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  function automatic act_t act_const(input logic [ACT_W-1:0] v);
    act_t a;
    for (int i = 0; i < N_CH; i++) a[i*ACT_W +: ACT_W] = v;
    return a;
  endfunction

  function automatic act_t act_ramp();
    act_t a;
    for (int i = 0; i < N_CH; i++) a[i*ACT_W +: ACT_W] = ACT_W'(i);
    return a;
  endfunction

  function automatic res_t to_res(input longint v);
    return v[ACC_W-1:0];
  endfunction

  // Result monitor: a handshake completes at the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!rst && bus.out_valid && bus.out_ready) res_q.push_back(bus.out_data);
  end

  // One-cycle reset with checks of the reset cycle and the state right after.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #2;
    check("reset_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    res_q.delete();
    #2;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_vec_cnt", bus.vec_cnt, 0);
    @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send(input act_t a, input wgt_t w, input len_t l);
    bit done = 1'b0;
    bus.act_in   = a;
    bus.wgt_in   = w;
    bus.cfg_len  = l;
    bus.in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if (bus.in_ready) done = 1'b1;
      @(negedge clk);
    end
    if (!done) check("send_timeout", 0, 1);
  endtask

  // Called on a falling edge after the last beat; returns at the sample point
  // where out_valid is first seen high (cyc = rising edges since acceptance).
  task automatic wait_valid(output int cyc);
    cyc = 0;
    #2;
    while (!bus.out_valid && cyc < 40) begin
      @(negedge clk);
      #2;
      cyc++;
    end
  endtask

  task automatic wait_results(input int n, input string name);
    int t = 0;
    while (res_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(name, res_q.size(), n);
  endtask

  vec_t tbl[$];
  int   cyc;
  bit   saw_drop;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.act_in    = '0;
    bus.wgt_in    = '0;
    bus.cfg_len   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

`ifdef SIGNED_WEIGHT_EN
    tbl.push_back('{"all_ffff",    act_const(16'hFFFF), 32'hFFFFFFFF, 5'd1,  2097120});
    tbl.push_back('{"ramp_odd",    act_ramp(),          32'hAAAAAAAA, 5'd1,  16});
    tbl.push_back('{"ramp_len0",   act_ramp(),          32'hAAAAAAAA, 5'd0,  16});
    tbl.push_back('{"ones_all",    act_const(16'd1),    32'hFFFFFFFF, 5'd1,  32});
    tbl.push_back('{"ramp_low16",  act_ramp(),          32'h0000FFFF, 5'd1,  -256});
    tbl.push_back('{"ones_w0",     act_const(16'd1),    32'h00000000, 5'd1,  -32});
    tbl.push_back('{"ones_hi16",   act_const(16'd1),    32'hFFFF0000, 5'd1,  0});
    tbl.push_back('{"ffff_w0",     act_const(16'hFFFF), 32'h00000000, 5'd1,  -2097120});
`else
    tbl.push_back('{"all_ffff",    act_const(16'hFFFF), 32'hFFFFFFFF, 5'd1,  2097120});
    tbl.push_back('{"ramp_odd",    act_ramp(),          32'hAAAAAAAA, 5'd1,  256});
    tbl.push_back('{"ramp_len0",   act_ramp(),          32'hAAAAAAAA, 5'd0,  256});
    tbl.push_back('{"ones_all",    act_const(16'd1),    32'hFFFFFFFF, 5'd1,  32});
    tbl.push_back('{"ramp_low16",  act_ramp(),          32'h0000FFFF, 5'd1,  120});
    tbl.push_back('{"ones_w0",     act_const(16'd1),    32'h00000000, 5'd1,  0});
    tbl.push_back('{"ones_hi16",   act_const(16'd1),    32'hFFFF0000, 5'd1,  16});
    tbl.push_back('{"ffff_w0",     act_const(16'hFFFF), 32'h00000000, 5'd1,  0});
`endif

    // Single-beat vectors: latency, value, one-cycle pulse, vec_cnt.
    foreach (tbl[i]) begin
      do_reset();
      send(tbl[i].act, tbl[i].wgt, tbl[i].len);
      bus.in_valid = 1'b0;
      wait_valid(cyc);
      check({tbl[i].name, "_latency"}, cyc, LAT);
      check({tbl[i].name, "_data"}, bus.out_data, to_res(tbl[i].exp));
      @(negedge clk);
      #2;
      check({tbl[i].name, "_pulse"}, bus.out_valid, 0);
      check({tbl[i].name, "_vec_cnt"}, bus.vec_cnt, 1);
      @(negedge clk);
    end

    // 16-beat vector, maximum length.
    do_reset();
    for (int b = 0; b < 16; b++) send(act_const(16'hFFFF), '1, 5'd16);
    bus.in_valid = 1'b0;
    wait_valid(cyc);
    check("len16_latency", cyc, LAT);
    check("len16_data", bus.out_data, 33553920);
    @(negedge clk);
    #2;
    check("len16_pulse", bus.out_valid, 0);
    check("len16_vec_cnt", bus.vec_cnt, 1);
    repeat (20) @(negedge clk);
    check("len16_count", res_q.size(), 1);

    // cfg_len above MAX_BEATS clamps to 16 beats.
    do_reset();
    for (int b = 0; b < 16; b++) send(act_const(16'hFFFF), '1, 5'd31);
    bus.in_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("clamp_count", res_q.size(), 1);
    if (res_q.size() > 0) check("clamp_data", res_q[0], 33553920);

    // cfg_len change on the second beat is ignored.
    do_reset();
    send(act_const(16'd1), '1, 5'd2);
    send(act_const(16'hFFFF), '1, 5'd1);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("midlen_count", res_q.size(), 1);
    if (res_q.size() > 0) check("midlen_data", res_q[0], 2097152);

    // Back-to-back length-1 vectors with out_ready high: no bubble, no loss.
    do_reset();
    for (int v = 1; v <= 4; v++) send(act_const(ACT_W'(v)), '1, 5'd1);
    bus.in_valid = 1'b0;
    wait_results(4, "b2b_count");
    for (int v = 0; v < res_q.size() && v < 4; v++)
      check($sformatf("b2b_data%0d", v), res_q[v], 32 * (v + 1));
    repeat (3) @(negedge clk);
    check("b2b_vec_cnt", bus.vec_cnt, 4);

    // Backpressure: ten length-1 vectors while out_ready is low.
    do_reset();
    bus.out_ready = 1'b0;
    saw_drop = 1'b0;
    fork
      begin
        for (int v = 0; v < 10; v++) send(act_const(16'd1), '1, 5'd1);
        bus.in_valid = 1'b0;
      end
      begin
        for (int t = 0; t < 100 && !saw_drop; t++) begin
          @(negedge clk);
          #2;
          if (!bus.in_ready) saw_drop = 1'b1;
        end
        repeat (5) @(negedge clk);
        bus.out_ready = 1'b1;
      end
    join
    check("bp_in_ready_drop", saw_drop, 1);
    wait_results(10, "bp_count");
    for (int v = 0; v < res_q.size() && v < 10; v++)
      check($sformatf("bp_data%0d", v), res_q[v], 32);
    repeat (10) @(negedge clk);
    check("bp_vec_cnt", bus.vec_cnt, 10);
    check("bp_no_extra", res_q.size(), 10);

    // Reset in the middle of a 4-beat vector discards the partial vector.
    do_reset();
    send(act_const(16'hFFFF), '1, 5'd4);
    send(act_const(16'hFFFF), '1, 5'd4);
    bus.in_valid = 1'b0;
    do_reset();
    send(act_const(16'd1), '1, 5'd1);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_count", res_q.size(), 1);
    if (res_q.size() > 0) check("rstmid_data", res_q[0], 32);
    check("rstmid_vec_cnt", bus.vec_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
